// File: rtl/digital_tube_pkg.sv
// Glyph table and receive-side types shared by both ends of the digit-tube scan link.
package digital_tube_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned GLYPH_N = 16;

  localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

  // Active-low segments, bit6 = A ... bit0 = G, indexed by the hex value shown.
  localparam logic [SEG_W-1:0] GLYPHS [GLYPH_N] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic             sel;
    logic [SEG_W-1:0] seg;
  } tube_sample_t;

  typedef enum logic {
    SETTLING = 1'b0,
    HELD     = 1'b1
  } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup of an active-low seven-segment pattern into a hex nibble.
module seg_glyph_decode
  import digital_tube_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             match,
  output logic [NIB_W-1:0] nibble
);

  // Glyphs are unique, so at most one entry can hit; blank never does.
  always_comb begin
    match  = 1'b0;
    nibble = '0;
    if (seg != BLANK) begin
      for (int unsigned i = 0; i < GLYPH_N; i++) begin
        if (seg == GLYPHS[i]) begin
          match  = 1'b1;
          nibble = NIB_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/digital_tube_decoder.sv
// Receive end of the two-digit tube scan bus: filters, decodes and tracks both digits
// and flags a stalled scan.
module digital_tube_decoder
  import digital_tube_pkg::*;
#(
  parameter int unsigned P_SETTLE  = 16,
  parameter int unsigned P_TIMEOUT = 1_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEG_W-1:0] i_digitalTube,
  input  logic             i_sel,
  output logic [NIB_W-1:0] o_hexHigh,
  output logic [NIB_W-1:0] o_hexLow,
  output logic             o_validHigh,
  output logic             o_validLow,
  output logic             o_update,
  output logic             o_err,
  output logic             o_stalled
);

  localparam int unsigned CNT_W   = $clog2(P_SETTLE + 1);
  localparam int unsigned STALL_W = $clog2(P_TIMEOUT + 1);

  tube_sample_t       sync_q1, sync_q2, s_prev;
  logic [CNT_W-1:0]   cnt;
  logic [STALL_W-1:0] stall_cnt;
  state_t             state, next_state;
  logic               capture;
  logic               stable;
  logic               sel_edge;
  logic               stall_fire;
  logic               dec_match;
  logic [NIB_W-1:0]   dec_nibble;
  logic               cur_valid;
  logic [NIB_W-1:0]   cur_hex;
  logic               cap_update;

  assign stable     = (sync_q2 == s_prev);
  assign sel_edge   = sync_q2.sel ^ s_prev.sel;
  assign stall_fire = !sel_edge && (stall_cnt == STALL_W'(P_TIMEOUT - 1));

  // Two-flop synchronizers on all eight lines, plus the previous-sample register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      s_prev  <= '0;
    end else begin
      sync_q1 <= {i_sel, i_digitalTube};
      sync_q2 <= sync_q1;
      s_prev  <= sync_q2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (!stable) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(P_SETTLE)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= SETTLING;
    end else begin
      state <= next_state;
    end
  end

  // One capture per stable interval: fire once on the settle threshold, then hold.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      SETTLING: begin
        if (stable && (cnt == CNT_W'(P_SETTLE - 1))) begin
          capture    = 1'b1;
          next_state = HELD;
        end
      end
      HELD: begin
        if (!stable) next_state = SETTLING;
      end
    endcase
  end

  seg_glyph_decode u_decode (
    .seg    (sync_q2.seg),
    .match  (dec_match),
    .nibble (dec_nibble)
  );

  assign cur_valid  = sync_q2.sel ? o_validHigh : o_validLow;
  assign cur_hex    = sync_q2.sel ? o_hexHigh   : o_hexLow;
  assign cap_update = capture && (dec_match ? (!cur_valid || (cur_hex != dec_nibble)) : cur_valid);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (sel_edge) begin
      stall_cnt <= '0;
    end else if (stall_cnt != STALL_W'(P_TIMEOUT)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  // Digit state; a stall clearing the valids overrides a same-cycle capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hexHigh   <= '0;
      o_hexLow    <= '0;
      o_validHigh <= 1'b0;
      o_validLow  <= 1'b0;
      o_update    <= 1'b0;
      o_err       <= 1'b0;
      o_stalled   <= 1'b0;
    end else begin
      o_update <= cap_update || (stall_fire && (o_validHigh || o_validLow));
      o_err    <= capture && !dec_match;
      if (capture) begin
        if (sync_q2.sel) begin
          if (dec_match) o_hexHigh <= dec_nibble;
          o_validHigh <= dec_match;
        end else begin
          if (dec_match) o_hexLow <= dec_nibble;
          o_validLow <= dec_match;
        end
      end
      if (sel_edge) begin
        o_stalled <= 1'b0;
      end else if (stall_fire) begin
        o_stalled   <= 1'b1;
        o_validHigh <= 1'b0;
        o_validLow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digital_tube_decoder.sv
// Randomized and directed bench for digital_tube_decoder against a run-length based
// behavioural model of the receive path.
module tb_digital_tube_decoder;

  localparam int P_SETTLE  = 4;
  localparam int P_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] i_digitalTube = 7'b1111111;
  logic       i_sel = 1'b1;
  logic [3:0] o_hexHigh, o_hexLow;
  logic       o_validHigh, o_validLow, o_update, o_err, o_stalled;

  always #5 clk = ~clk;

  digital_tube_decoder #(
    .P_SETTLE  (P_SETTLE),
    .P_TIMEOUT (P_TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_digitalTube (i_digitalTube),
    .i_sel         (i_sel),
    .o_hexHigh     (o_hexHigh),
    .o_hexLow      (o_hexLow),
    .o_validHigh   (o_validHigh),
    .o_validLow    (o_validLow),
    .o_update      (o_update),
    .o_err         (o_err),
    .o_stalled     (o_stalled)
  );

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_cmp = 0;
  int n_bad = 0;
  logic checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a capture happens when the raw input sample two edges back closes a run of
  // exactly P_SETTLE+1 identical samples; sel edges are seen two edges after the input.
  logic [3:0] m_hex [2];
  logic       m_vld [2];
  logic       m_upd, m_err, m_stall;
  logic [7:0] xq [$];
  int         rq [$];
  int         e_idx, last_sel;

  task automatic glyph_lookup(input logic [6:0] seg, output logic hit, output logic [3:0] nib);
    hit = 1'b0;
    nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == seg) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    end
  endtask

  task automatic model_reset();
    m_hex[0] = 4'h0; m_hex[1] = 4'h0;
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    m_upd = 1'b0; m_err = 1'b0; m_stall = 1'b0;
    xq = '{8'h00, 8'h00, 8'h00};
    rq = '{0, 0, 0};
    e_idx = 0;
    last_sel = 0;
  endtask

  task automatic model_step();
    logic [7:0] x, p;
    logic       hit, any_vld;
    logic [3:0] nib;
    int         rl, d;
    if (rst) begin
      model_reset();
      return;
    end
    x  = {i_sel, i_digitalTube};
    rl = (x == xq[$]) ? rq[$] + 1 : 1;
    xq.push_back(x);
    rq.push_back(rl);
    if (xq.size() > 4) begin
      void'(xq.pop_front());
      void'(rq.pop_front());
    end
    e_idx++;
    m_upd   = 1'b0;
    m_err   = 1'b0;
    any_vld = m_vld[0] | m_vld[1];
    p       = xq[1];
    if (rq[1] == P_SETTLE + 1) begin
      d = int'(p[7]);
      glyph_lookup(p[6:0], hit, nib);
      if (hit) begin
        if (!m_vld[d] || m_hex[d] != nib) m_upd = 1'b1;
        m_hex[d] = nib;
        m_vld[d] = 1'b1;
      end else begin
        m_err = 1'b1;
        if (m_vld[d]) m_upd = 1'b1;
        m_vld[d] = 1'b0;
      end
    end
    if (xq[1][7] != xq[0][7]) begin
      last_sel = e_idx;
      m_stall  = 1'b0;
    end else if (e_idx - last_sel == P_TIMEOUT) begin
      m_stall  = 1'b1;
      m_vld[0] = 1'b0;
      m_vld[1] = 1'b0;
      if (any_vld) m_upd = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (checking)
      check("cycle", 32'({o_hexHigh, o_hexLow, o_validHigh, o_validLow, o_update, o_err, o_stalled}),
                     32'({m_hex[1], m_hex[0], m_vld[1], m_vld[0], m_upd, m_err, m_stall}));
  end

  task automatic drive(input logic sel, input logic [6:0] seg, input int cycles,
                       output int upd, output int err, output int first_upd, output int first_stall);
    @(negedge clk);
    i_sel         = sel;
    i_digitalTube = seg;
    upd = 0; err = 0; first_upd = -1; first_stall = -1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      #1;
      if (o_update) begin
        upd++;
        if (first_upd < 0) first_upd = k - 1;
      end
      if (o_err) err++;
      if (o_stalled && first_stall < 0) first_stall = k - 1;
    end
  endtask

  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] G8 = 7'b0000000;

  initial begin
    int u, er, fu, fs, su, se, pulses, len;
    logic       rs;
    logic [6:0] rseg;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    #1 check("reset_state", 32'({o_hexHigh, o_hexLow, o_validHigh, o_validLow, o_update, o_err, o_stalled}), 32'h0);

    // High digit 4 held: single update six edges after the first stable edge.
    drive(1'b1, G4, 10, u, er, fu, fs);
    check("s1_update_count", 32'(u), 32'd1);
    check("s1_update_cycle", 32'(fu), 32'd6);
    check("s1_hex_high", 32'(o_hexHigh), 32'h4);
    check("s1_valid_high", 32'(o_validHigh), 32'd1);

    // Alternating scan: only the first capture of each digit changes anything.
    su = 0;
    drive(1'b0, G3, 19, u, er, fu, fs); su += u;
    drive(1'b1, GA, 19, u, er, fu, fs); su += u;
    drive(1'b0, G3, 19, u, er, fu, fs); su += u;
    drive(1'b1, GA, 19, u, er, fu, fs); su += u;
    check("s2_update_count", 32'(su), 32'd2);
    check("s2_hex", 32'({o_hexHigh, o_hexLow}), 32'hA3);
    check("s2_valids", 32'({o_validHigh, o_validLow}), 32'h3);

    // Short glitch inside a stable low 5.
    drive(1'b0, G5, 12, u, er, fu, fs);
    su = 0; se = 0;
    drive(1'b0, 7'b1110000, 2, u, er, fu, fs); su += u; se += er;
    drive(1'b0, G5, 12, u, er, fu, fs);        su += u; se += er;
    check("s3_glitch_err", 32'(se), 32'd0);
    check("s3_glitch_update", 32'(su), 32'd0);
    check("s3_hex_low", 32'(o_hexLow), 32'h5);

    // Blank after a valid low 7.
    drive(1'b1, GA, 10, u, er, fu, fs);
    drive(1'b0, G7, 12, u, er, fu, fs);
    drive(1'b0, 7'b1111111, 12, u, er, fu, fs);
    check("s4_blank_err", 32'(er), 32'd1);
    check("s4_blank_update", 32'(u), 32'd1);
    check("s4_valid_low", 32'(o_validLow), 32'd0);
    check("s4_hex_low", 32'(o_hexLow), 32'h7);

    // Scan freeze with both digits valid, then recovery on the next sel edge.
    drive(1'b0, G3, 12, u, er, fu, fs);
    drive(1'b1, GA, 10, u, er, fu, fs);
    drive(1'b0, G3, 80, u, er, fu, fs);
    check("s5_stall_cycle", 32'(fs), 32'd66);
    check("s5_stall_update", 32'(u), 32'd1);
    check("s5_stalled", 32'(o_stalled), 32'd1);
    check("s5_valids_cleared", 32'({o_validHigh, o_validLow}), 32'h0);
    drive(1'b1, GA, 10, u, er, fu, fs);
    check("s5_stall_cleared", 32'(o_stalled), 32'd0);
    check("s5_recapture_high", 32'({o_validHigh, o_hexHigh}), 32'h1A);

    // Asynchronous reset two cycles into a settle.
    @(negedge clk);
    i_sel = 1'b1;
    i_digitalTube = G8;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'({o_hexHigh, o_hexLow, o_validHigh, o_validLow, o_update, o_err, o_stalled}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (o_update || o_err) pulses++;
    end
    check("post_reset_pulses", 32'(pulses), 32'd0);

    // Random scan traffic: mostly glyphs, some junk, occasional long freezes.
    repeat (120) begin
      rs   = 1'($urandom_range(0, 1));
      rseg = ($urandom_range(0, 9) < 7) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
      len  = ($urandom_range(0, 19) == 0) ? 75 : $urandom_range(1, 12);
      drive(rs, rseg, len, u, er, fu, fs);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
